// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register ids,
// the decode-register bundle and the per-icode decode rules.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [1:0] SAOK = 2'b00;
    localparam logic [1:0] SHLT = 2'b01;
    localparam logic [1:0] SADR = 2'b10;
    localparam logic [1:0] SINS = 2'b11;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dreg_t;

    // Contents written into the decode register on reset or bubble.
    localparam dreg_t D_NOP = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                                ra: RNONE, rb: RNONE, valc: 64'h0, valp: 64'h0};

    function automatic logic need_regids(input logic [3:0] icode);
        case (icode)
            IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic need_valc(input logic [3:0] icode);
        case (icode)
            IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic instr_invalid(input logic [3:0] icode, input logic [3:0] ifun);
        logic bad;
        case (icode)
            IRRMOVQ, IJXX: bad = (ifun > 4'd6);
            IOPQ:          bad = (ifun > 4'd3);
            IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ:
                           bad = (ifun != 4'd0);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/f_align.sv
// Combinational fetch decode: splits the 10 instruction bytes into fields,
// classifies the instruction and produces valP and the predicted next PC.
module f_align
    import y86_pkg::*;
(
    input  logic [63:0] pc,
    input  logic [79:0] imem_bytes,
    input  logic        imem_error,
    output dreg_t       f_out,
    output logic [63:0] pred_pc
);

    logic [3:0] icode;
    logic [3:0] ifun;
    logic       regids;
    logic       valc_n;
    logic       invalid;

    // NOTE: every signal written in an always_comb gets a value on every path
    // (defaults first); a missed branch would otherwise infer a latch.
    always_comb begin
        icode = imem_bytes[7:4];
        ifun  = imem_bytes[3:0];
        if (imem_error) begin
            icode = INOP;
            ifun  = 4'h0;
        end

        regids  = need_regids(icode);
        valc_n  = need_valc(icode);
        invalid = instr_invalid(icode, ifun);

        f_out       = D_NOP;
        f_out.icode = icode;
        f_out.ifun  = ifun;
        if (regids) begin
            f_out.ra = imem_bytes[15:12];
            f_out.rb = imem_bytes[11:8];
        end

        // Constant follows the register byte when one is present.
        if (valc_n)
            f_out.valc = regids ? imem_bytes[79:16] : imem_bytes[71:8];

        f_out.valp = pc + 64'd1 + 64'(regids) + (valc_n ? 64'd8 : 64'd0);

        if (imem_error)
            f_out.stat = SADR;
        else if (invalid)
            f_out.stat = SINS;
        else if (icode == IHALT)
            f_out.stat = SHLT;
        else
            f_out.stat = SAOK;

        pred_pc = (icode == IJXX || icode == ICALL) ? f_out.valc : f_out.valp;
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: selects the fetch PC, decodes via f_align and holds the
// F (predicted PC) and D (fetched instruction) pipeline registers.
module fetch_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_bytes,
    input  logic        imem_error,
    output logic [1:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    logic [63:0] f_pred_pc;
    logic [63:0] f_pc;
    logic [63:0] pred_pc;
    dreg_t       f_dec;
    dreg_t       d_q;

    // A mispredicted not-taken jump outranks a returning ret.
    always_comb begin
        if (M_icode == IJXX && !M_Cnd)
            f_pc = M_valA;
        else if (W_icode == IRET)
            f_pc = W_valM;
        else
            f_pc = f_pred_pc;
    end

    assign imem_addr = f_pc;

    f_align u_align (
        .pc         (f_pc),
        .imem_bytes (imem_bytes),
        .imem_error (imem_error),
        .f_out      (f_dec),
        .pred_pc    (pred_pc)
    );

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst)
            f_pred_pc <= RESET_PC;
        else if (!F_stall)
            f_pred_pc <= pred_pc;
    end

    // Stall wins over bubble: a stalled D keeps its instruction.
    always_ff @(posedge clk) begin
        if (rst)
            d_q <= D_NOP;
        else if (!D_stall) begin
            if (D_bubble)
                d_q <= D_NOP;
            else
                d_q <= f_dec;
        end
    end

    assign D_stat  = d_q.stat;
    assign D_icode = d_q.icode;
    assign D_ifun  = d_q.ifun;
    assign D_rA    = d_q.ra;
    assign D_rB    = d_q.rb;
    assign D_valC  = d_q.valc;
    assign D_valP  = d_q.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a table-driven instruction model predicts
// f_pc and the D register; a monitor compares them against the DUT each cycle.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC  = 64'h0;
    localparam logic [63:0] MEM_TOP = 64'd246;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } exp_t;

    localparam exp_t NOP_E = '{stat: 2'b00, icode: 4'h1, ifun: 4'h0, ra: 4'hF,
                               rb: 4'hF, valc: 64'h0, valp: 64'h0};

    logic        clk = 1'b0;
    logic        rst, F_stall, D_stall, D_bubble, M_Cnd, imem_error, force_err;
    logic [3:0]  M_icode, W_icode;
    logic [63:0] M_valA, W_valM, imem_addr;
    logic [79:0] imem_bytes;
    logic [1:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;

    logic [7:0]  mem [0:255];
    int          len_tbl  [0:11] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
    int          max_ifun [0:11] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};

    logic [63:0] q_pc [$];
    exp_t        q_d  [$];
    logic [63:0] m_pred;
    exp_t        m_d;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .D_bubble   (D_bubble),
        .M_icode    (M_icode),
        .M_Cnd      (M_Cnd),
        .M_valA     (M_valA),
        .W_icode    (W_icode),
        .W_valM     (W_valM),
        .imem_addr  (imem_addr),
        .imem_bytes (imem_bytes),
        .imem_error (imem_error),
        .D_stat     (D_stat),
        .D_icode    (D_icode),
        .D_ifun     (D_ifun),
        .D_rA       (D_rA),
        .D_rB       (D_rB),
        .D_valC     (D_valC),
        .D_valP     (D_valP)
    );

    // Instruction memory: 256 bytes, fetches that would run past the end fault.
    always_comb begin
        imem_error = force_err || (imem_addr > MEM_TOP);
        imem_bytes = '0;
        if (!imem_error)
            for (int k = 0; k < 10; k++)
                imem_bytes[8*k +: 8] = mem[int'(imem_addr[7:0]) + k];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction semantics from length and ifun-range tables.
    function automatic exp_t model_fetch(input logic [63:0] pc, input bit err);
        exp_t e;
        int   len, base, off;
        e = NOP_E;
        e.valp = pc + 64'd1;
        if (err) begin
            e.stat = 2'b10;
            return e;
        end
        base    = int'(pc[7:0]);
        e.icode = mem[base][7:4];
        e.ifun  = mem[base][3:0];
        if (e.icode > 4'd11) begin
            e.stat = 2'b11;
            return e;
        end
        len = len_tbl[e.icode];
        if (len == 2 || len == 10) begin
            e.ra = mem[base + 1][7:4];
            e.rb = mem[base + 1][3:0];
        end
        if (len >= 9) begin
            off = (len == 10) ? 2 : 1;
            for (int i = 0; i < 8; i++)
                e.valc = e.valc | (64'(mem[base + off + i]) << (8 * i));
        end
        e.valp = pc + 64'(len);
        if (int'(e.ifun) > max_ifun[e.icode]) e.stat = 2'b11;
        else if (e.icode == 4'h0)             e.stat = 2'b01;
        return e;
    endfunction

    // One clock of stimulus: drive, predict, enqueue, advance to next negedge.
    task automatic step(input bit r, input bit fs, input bit ds, input bit db,
                        input logic [3:0] mi, input bit mc, input logic [63:0] mv,
                        input logic [3:0] wi, input logic [63:0] wv, input bit fe);
        logic [63:0] fpc;
        exp_t        f;
        rst = r; F_stall = fs; D_stall = ds; D_bubble = db;
        M_icode = mi; M_Cnd = mc; M_valA = mv; W_icode = wi; W_valM = wv; force_err = fe;
        if (mi == 4'h7 && !mc) fpc = mv;
        else if (wi == 4'h9)   fpc = wv;
        else                   fpc = m_pred;
        f = model_fetch(fpc, fe || fpc > MEM_TOP);
        q_pc.push_back(fpc);
        if (r)        m_d = NOP_E;
        else if (ds)  m_d = m_d;
        else if (db)  m_d = NOP_E;
        else          m_d = f;
        if (r)
            m_pred = RST_PC;
        else if (!fs)
            m_pred = (f.icode == 4'h7 || f.icode == 4'h8) ? f.valc : f.valp;
        q_d.push_back(m_d);
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0);
    endtask

    task automatic peek_pc(input string name, input logic [63:0] exp);
        M_icode = 4'h0;
        W_icode = 4'h0;
        #1;
        check(name, imem_addr, exp);
    endtask

    // Monitor: f_pc before each edge, D register just after it.
    initial begin
        logic [63:0] epc;
        exp_t        ed;
        forever begin
            @(negedge clk);
            #3;
            if (q_pc.size() > 0) begin
                epc = q_pc.pop_front();
                check("f_pc", imem_addr, epc);
            end
            @(posedge clk);
            #1;
            if (q_d.size() > 0) begin
                ed = q_d.pop_front();
                check("D_stat",  64'(D_stat),  64'(ed.stat));
                check("D_icode", 64'(D_icode), 64'(ed.icode));
                check("D_ifun",  64'(D_ifun),  64'(ed.ifun));
                check("D_rA",    64'(D_rA),    64'(ed.ra));
                check("D_rB",    64'(D_rB),    64'(ed.rb));
                check("D_valC",  D_valC,       ed.valc);
                check("D_valP",  D_valP,       ed.valp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h10;
        mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h23; mem[3] = 8'h01;
        for (int i = 4; i < 10; i++) mem[i] = 8'h00;
        mem[32] = 8'h70; mem[33] = 8'h40;
        for (int i = 34; i < 41; i++) mem[i] = 8'h00;
        mem[80] = 8'hC0;
        mem[96] = 8'h00;

        rst = 1; F_stall = 0; D_stall = 0; D_bubble = 0; force_err = 0;
        M_icode = 0; M_Cnd = 0; M_valA = 0; W_icode = 0; W_valM = 0;
        m_pred = RST_PC;
        m_d    = NOP_E;
        repeat (2) @(negedge clk);

        step(1, 0, 0, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0);
        check("reset_icode", 64'(D_icode), 64'h1);
        check("reset_rA", 64'(D_rA), 64'hF);
        peek_pc("reset_pc", RST_PC);

        idle_step();
        check("irmovq_icode", 64'(D_icode), 64'h3);
        check("irmovq_rA", 64'(D_rA), 64'hF);
        check("irmovq_rB", 64'(D_rB), 64'h2);
        check("irmovq_valC", D_valC, 64'h0123);
        check("irmovq_valP", D_valP, 64'd10);
        peek_pc("irmovq_next_pc", 64'd10);

        step(0, 0, 0, 0, 4'h0, 0, 64'h0, 4'h9, 64'h20, 0);
        check("jxx_valC", D_valC, 64'h40);
        peek_pc("jxx_pred_pc", 64'h40);
        idle_step();
        step(0, 0, 0, 0, 4'h7, 0, 64'h29, 4'h0, 64'h0, 0);
        check("mispredict_valP", D_valP, 64'h2A);

        step(0, 0, 0, 0, 4'h0, 0, 64'h0, 4'h9, 64'h100, 0);
        check("ret_adr_stat", 64'(D_stat), 64'h2);
        check("ret_adr_icode", 64'(D_icode), 64'h1);
        step(0, 0, 0, 0, 4'h7, 0, 64'h60, 4'h9, 64'h50, 0);
        check("halt_stat", 64'(D_stat), 64'h1);
        check("halt_valP", D_valP, 64'h61);
        step(0, 0, 0, 0, 4'h0, 0, 64'h0, 4'h9, 64'h50, 0);
        check("ins_stat", 64'(D_stat), 64'h3);

        step(0, 0, 1, 1, 4'h0, 0, 64'h0, 4'h9, 64'h0, 0);
        check("stall_bubble_stat", 64'(D_stat), 64'h3);
        check("stall_bubble_icode", 64'(D_icode), 64'hC);
        step(0, 0, 0, 1, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0);
        check("bubble_icode", 64'(D_icode), 64'h1);
        check("bubble_valP", D_valP, 64'h0);
        step(0, 1, 0, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0);
        step(0, 1, 0, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0);
        peek_pc("fstall_hold", 64'd11);

        step(1, 1, 1, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0);
        check("midrst_icode", 64'(D_icode), 64'h1);
        peek_pc("midrst_pc", RST_PC);
        idle_step();
        check("after_rst_icode", 64'(D_icode), 64'h3);

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 400; n++) begin
            bit          r, fs, ds, db, mc, fe;
            logic [3:0]  mi, wi;
            logic [63:0] mv, wv;
            if ($urandom_range(0, 7) == 0) begin
                int a = $urandom_range(0, 255);
                mem[a] = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 2))};
            end
            r  = ($urandom_range(0, 63) == 0);
            fs = ($urandom_range(0, 7) == 0);
            ds = ($urandom_range(0, 7) == 0);
            db = ($urandom_range(0, 7) == 0);
            mi = ($urandom_range(0, 5) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
            mc = 1'($urandom);
            mv = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
            wi = ($urandom_range(0, 7) == 0) ? 4'h9 : 4'($urandom_range(0, 8));
            wv = 64'($urandom_range(0, 260));
            fe = ($urandom_range(0, 31) == 0);
            step(r, fs, ds, db, mi, mc, mv, wi, wv, fe);
        end

        idle_step();
        repeat (2) @(negedge clk);
        check("queues_drained", 64'(q_pc.size() + q_d.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
